smart_home_ctrl_param: RTL

// - Parametrised next-generation smart-home controller FSM: front door, rear door, N window sensors, fire alarm, temperature.
// - Adds prioritised arbitration, a front-door hold timer, heater/cooler hysteresis and configurable temperature width/thresholds.
// - Sits between raw sensor inputs and actuator/7-seg display drivers. Moore outputs, all registered.

---
 rtl/smart_home_ctrl_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/smart_home_ctrl_param.sv
// Smart-home controller: prioritised sensor arbitration, front-door hold timer, heater/cooler hysteresis.
// Optional build macro ALARM_LATCH_EN makes ALARM sticky until acknowledged with the fire sensor clear.
module smart_home_ctrl_param #(
   parameter int TEMP_W    = 7,
   parameter int T_LOW     = 50,
   parameter int T_HIGH    = 80,
   parameter int HYST      = 2,
   parameter int N_WIN     = 4,
   parameter int DOOR_HOLD = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              SFD,
   input  logic              SRD,
   input  logic [N_WIN-1:0]  SW,
   input  logic              SFA,
   input  logic [TEMP_W-1:0] ST,
   input  logic              Ack,
   output logic              fdoor,
   output logic              rdoor,
   output logic              winbuzz,
   output logic              alarmbuzz,
   output logic              heater,
   output logic              cooler,
   output logic [2:0]        display
);

   localparam int CNT_W = $clog2(DOOR_HOLD + 1);

   localparam logic [TEMP_W-1:0] HEAT_ON_C  = TEMP_W'(T_LOW);
   localparam logic [TEMP_W-1:0] HEAT_OFF_C = TEMP_W'(T_LOW + HYST);
   localparam logic [TEMP_W-1:0] COOL_ON_C  = TEMP_W'(T_HIGH);
   localparam logic [TEMP_W-1:0] COOL_OFF_C = TEMP_W'(T_HIGH - HYST);
   localparam logic [CNT_W-1:0]  HOLD_C     = CNT_W'(DOOR_HOLD);

   if (N_WIN < 1 || DOOR_HOLD < 1 || HYST < 0 ||
       (T_LOW + HYST) > (T_HIGH - HYST) ||
       T_LOW < 0 || (T_LOW + HYST) >= (1 << TEMP_W) || T_HIGH >= (1 << TEMP_W)) begin : g_bad_params
      $error("smart_home_ctrl_param: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FDOOR   = 3'd1,
      S_RDOOR   = 3'd2,
      S_WINBUZZ = 3'd3,
      S_ALARM   = 3'd4,
      S_HEATER  = 3'd5,
      S_COOLER  = 3'd6
   } state_t;

   state_t             state, next_state;
   logic [CNT_W-1:0]   hold_cnt, hold_nxt;
   logic               heat_req, cool_req, heat_nxt, cool_nxt;
   logic               alarm_req, front_req;

   // Hysteresis requests feed arbitration as next-values so a temperature change shows after one edge.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      heat_nxt = heat_req;
      cool_nxt = cool_req;
      if (ST < HEAT_ON_C)        heat_nxt = 1'b1;
      else if (ST >= HEAT_OFF_C) heat_nxt = 1'b0;
      if (ST > COOL_ON_C)        cool_nxt = 1'b1;
      else if (ST <= COOL_OFF_C) cool_nxt = 1'b0;
   end

`ifdef ALARM_LATCH_EN
   assign alarm_req = SFA || (state == S_ALARM && !Ack);
`else
   assign alarm_req = SFA;
   logic unused_ack;
   assign unused_ack = Ack;
`endif

   assign front_req = SFD || (hold_cnt != '0);

   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE, S_FDOOR, S_RDOOR, S_WINBUZZ, S_ALARM, S_HEATER, S_COOLER: begin
            if (alarm_req)      next_state = S_ALARM;
            else if (front_req) next_state = S_FDOOR;
            else if (SRD)       next_state = S_RDOOR;
            else if (|SW)       next_state = S_WINBUZZ;
            else if (heat_nxt)  next_state = S_HEATER;
            else if (cool_nxt)  next_state = S_COOLER;
            else                next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Fire cancels any pending door hold at the moment ALARM is entered, overriding an SFD load.
   always_comb begin
      hold_nxt = hold_cnt;
      if (next_state == S_ALARM && state != S_ALARM) hold_nxt = '0;
      else if (SFD)                                  hold_nxt = HOLD_C;
      else if (hold_cnt != '0)                       hold_nxt = hold_cnt - CNT_W'(1);
   end

   // Outputs are decoded from next_state into flops so they change together with the state register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state     <= S_IDLE;
         hold_cnt  <= '0;
         heat_req  <= 1'b0;
         cool_req  <= 1'b0;
         fdoor     <= 1'b0;
         rdoor     <= 1'b0;
         winbuzz   <= 1'b0;
         alarmbuzz <= 1'b0;
         heater    <= 1'b0;
         cooler    <= 1'b0;
         display   <= 3'd0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
         state     <= next_state;
         hold_cnt  <= hold_nxt;
         heat_req  <= heat_nxt;
         cool_req  <= cool_nxt;
         fdoor     <= (next_state == S_FDOOR);
         rdoor     <= (next_state == S_RDOOR);
         winbuzz   <= (next_state == S_WINBUZZ);
         alarmbuzz <= (next_state == S_ALARM);
         heater    <= (next_state == S_HEATER);
         cooler    <= (next_state == S_COOLER);
         display   <= next_state;
      end
   end

endmodule
